// File: rtl/alu_pkg.sv
// Shared definitions for the ALU decode/issue stage: ALU opcodes, RV32 major
// opcodes and the issue-entry layout carried through the output buffer.
package alu_pkg;

    localparam int XLEN       = 32;
    localparam int SKID_DEPTH = 2;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1110;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [31:0] op0;
        logic [31:0] op1;
        logic [3:0]  opcode;
        logic [4:0]  rd;
    } issue_t;

    localparam int ENTRY_W = $bits(issue_t);

endpackage

// File: rtl/skid_buffer2.sv
// Generic two-entry valid/ready register slice. Upstream ready is a pure
// register output (skid slot empty), so it never depends on out_ready.
module skid_buffer2 #(
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] head_reg, head_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             head_valid_reg, head_valid_next;
    logic             skid_valid_reg, skid_valid_next;
    logic             push;
    logic             pop;

    assign in_ready  = ~skid_valid_reg;
    assign out_valid = head_valid_reg;
    assign out_data  = head_reg;

    assign push = in_valid & ~skid_valid_reg;
    assign pop  = head_valid_reg & out_ready;

    always_comb begin
        head_next       = head_reg;
        skid_next       = skid_reg;
        head_valid_next = head_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (pop) begin
            // Skid full implies no push this edge, so refill from skid first.
            if (skid_valid_reg) begin
                head_next       = skid_reg;
                skid_valid_next = 1'b0;
            end else if (push) begin
                head_next = in_data;
            end else begin
                head_valid_next = 1'b0;
            end
        end else if (push) begin
            if (head_valid_reg) begin
                skid_next       = in_data;
                skid_valid_next = 1'b1;
            end else begin
                head_next       = in_data;
                head_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg       <= '0;
            skid_reg       <= '0;
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            head_reg       <= head_next;
            skid_reg       <= skid_next;
            head_valid_reg <= head_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode/issue stage in front of the ALU: combinational RV32I decode of
// OP, OP-IMM, LUI and AUIPC feeding a registered two-entry output buffer.
module alu_decode_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            alu_en,
    output logic [XLEN-1:0] op0,
    output logic [XLEN-1:0] op1,
    output logic [3:0]      opcode,
    output logic [4:0]      rd,
    output logic            illegal
);

    issue_t     dec;
    issue_t     head;
    logic       legal;
    logic       accept;
    logic       illegal_reg;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_rs1_idx;

    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];
    // Register indices are resolved upstream; only the data is consumed here.
    assign unused_rs1_idx = ^in_instr[19:15];

    always_comb begin
        dec        = '0;
        legal      = 1'b0;
        dec.rd     = in_instr[11:7];
        case (in_instr[6:0])
            OPC_OP: begin
                legal      = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                dec.op0    = rs1_data;
                dec.op1    = rs2_data;
                dec.opcode = {f3, ((f3 == 3'b000) || (f3 == 3'b101)) ? f7[5] : 1'b0};
            end
            OPC_OPIMM: begin
                legal      = 1'b1;
                dec.op0    = rs1_data;
                dec.op1    = {{20{in_instr[31]}}, in_instr[31:20]};
                dec.opcode = {f3, 1'b0};
                if (f3 == 3'b001) begin
                    dec.op1 = {27'b0, in_instr[24:20]};
                    legal   = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec.op1    = {27'b0, in_instr[24:20]};
                    dec.opcode = {f3, in_instr[30]};
                    legal      = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                end
            end
            OPC_LUI: begin
                legal      = 1'b1;
                dec.op1    = {in_instr[31:12], 12'b0};
                dec.opcode = ALU_ADD;
            end
            OPC_AUIPC: begin
                legal      = 1'b1;
                dec.op0    = in_pc;
                dec.op1    = {in_instr[31:12], 12'b0};
                dec.opcode = ALU_ADD;
            end
            default: legal = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Illegal instructions are consumed (in_ready honoured) but never enqueued.
    skid_buffer2 #(
        .WIDTH(ENTRY_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid & legal),
        .in_ready (in_ready),
        .in_data  (dec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else begin
            illegal_reg <= accept & ~legal;
        end
    end

    assign illegal = illegal_reg;
    assign alu_en  = out_valid & out_ready;
    assign op0     = head.op0;
    assign op1     = head.op1;
    assign opcode  = head.opcode;
    assign rd      = head.rd;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized and directed bench for alu_decode_stage against a mnemonic-level
// decode model and an expected-entry FIFO.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic        alu_en;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic        illegal;

    alu_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_ready(out_ready), .out_valid(out_valid), .alu_en(alu_en),
        .op0(op0), .op1(op1), .opcode(opcode), .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
    } stim_t;

    typedef struct {
        logic [31:0] op0;
        logic [31:0] op1;
        logic [3:0]  opc;
        logic [4:0]  rd;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    bit    ill_exp;
    int    cyc, stall_s, stall_l, en_cnt;
    int    total = 0;
    int    bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] code_of(input string mn);
        case (mn)
            "add":  return 4'd0;
            "sub":  return 4'd1;
            "sll":  return 4'd2;
            "slt":  return 4'd4;
            "sltu": return 4'd6;
            "xor":  return 4'd8;
            "srl":  return 4'd10;
            "sra":  return 4'd11;
            "or":   return 4'd12;
            "and":  return 4'd14;
            default: return 4'hx;
        endcase
    endfunction

    // Model: classify the instruction into a mnemonic and operands, then map.
    function automatic bit ref_decode(input stim_t s, output exp_t e);
        string names[8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
        int    f3 = int'(s.instr[14:12]);
        int    f7 = int'(s.instr[31:25]);
        int    imm = int'(s.instr[31:20]);
        string mn;
        if (imm >= 2048) imm -= 4096;
        e.rd = s.instr[11:7];
        case (s.instr[6:0])
            7'h33: begin
                if (f7 != 0 && f7 != 32) return 1'b0;
                mn = names[f3];
                if (f7 == 32 && f3 == 0) mn = "sub";
                if (f7 == 32 && f3 == 5) mn = "sra";
                e.op0 = s.a;
                e.op1 = s.b;
            end
            7'h13: begin
                if (f3 == 1 && f7 != 0) return 1'b0;
                if (f3 == 5 && f7 != 0 && f7 != 32) return 1'b0;
                mn = names[f3];
                e.op0 = s.a;
                e.op1 = imm;
                if (f3 == 1 || f3 == 5) e.op1 = int'(s.instr[24:20]);
                if (f3 == 5 && f7 == 32) mn = "sra";
            end
            7'h37: begin
                mn = "add";
                e.op0 = 0;
                e.op1 = int'(s.instr[31:12]) * 4096;
            end
            7'h17: begin
                mn = "add";
                e.op0 = s.pc;
                e.op1 = int'(s.instr[31:12]) * 4096;
            end
            default: return 1'b0;
        endcase
        e.opc = code_of(mn);
        return 1'b1;
    endfunction

    function automatic logic [31:0] rand_alu_instr();
        logic [2:0]  f3 = 3'($urandom);
        logic [4:0]  rdi = 5'($urandom);
        logic [4:0]  r1 = 5'($urandom);
        logic [4:0]  r2 = 5'($urandom);
        logic [11:0] imm = 12'($urandom);
        logic [6:0]  f7;
        if ($urandom_range(0, 1) == 0) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return {f7, r2, r1, f3, rdi, 7'h33};
        end
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {imm, r1, f3, rdi, 7'h13};
    endfunction

    task automatic add_stim(input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b);
        stim_t s;
        s.instr = instr; s.pc = pc; s.a = a; s.b = b;
        stim_q.push_back(s);
    endtask

    task automatic apply();
        in_valid = (stim_q.size() > 0);
        if (in_valid) begin
            in_instr = stim_q[0].instr; in_pc = stim_q[0].pc;
            rs1_data = stim_q[0].a;     rs2_data = stim_q[0].b;
        end else begin
            in_instr = $urandom; in_pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
        end
        out_ready = !(cyc >= stall_s && cyc < stall_s + stall_l);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        check_eq("in_ready", in_ready, exp_q.size() < 2);
        check_eq("out_valid", out_valid, exp_q.size() > 0);
        check_eq("illegal", illegal, ill_exp);
        check_eq("alu_en", alu_en, (exp_q.size() > 0) && out_ready);
        if (ill_exp) $display("illegal pulse observed");
        if (out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("op0", op0, e.op0);
            check_eq("op1", op1, e.op1);
            check_eq("opcode", opcode, e.opc);
            check_eq("rd", rd, e.rd);
            en_cnt++;
            $display("alu_en op0=%h op1=%h opcode=%b rd=%0d", op0, op1, opcode, rd);
        end
        ill_exp = 1'b0;
        if (in_valid && in_ready) begin
            if (ref_decode(stim_q[0], e)) exp_q.push_back(e);
            else ill_exp = 1'b1;
            void'(stim_q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        apply();
    endtask

    task automatic run(input int s, input int l, input int budget);
        stall_s = s; stall_l = l; cyc = 0; en_cnt = 0;
        apply();
        while ((stim_q.size() > 0 || exp_q.size() > 0 || ill_exp) && cyc < budget) step();
        check_eq("timeout", stim_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        stall_s = 0; stall_l = 0; cyc = 0; ill_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_op0", op0, 0);
        check_eq("rst_opcode", opcode, 0);
        rst = 1'b0;

        // Register-register add/sub
        add_stim(32'h002081B3, 32'h0, 32'd5, 32'd7);
        add_stim(32'h402081B3, 32'h0, 32'd5, 32'd7);
        run(100, 0, 20);

        // Immediates, LUI, AUIPC
        add_stim(32'hFFF00093, 32'h0, 32'h0, 32'h0);
        add_stim(32'h4040D093, 32'h0, 32'h80000000, 32'h0);
        add_stim(32'h123452B7, 32'h0, 32'hDEADBEEF, 32'h0);
        add_stim(32'h00001317, 32'h100, 32'h0, 32'h0);
        run(100, 0, 20);

        // Illegal load, then a legal one right behind it
        add_stim(32'h0000A083, 32'h0, 32'h1, 32'h2);
        add_stim(32'h00100093, 32'h0, 32'h3, 32'h4);
        run(100, 0, 20);

        // Backpressure: stall 3 cycles after the first accept
        for (int i = 0; i < 4; i++) add_stim(rand_alu_instr(), $urandom, $urandom, $urandom);
        run(1, 3, 40);
        check_eq("bp_count", en_cnt, 4);

        // Full-rate random stream
        for (int i = 0; i < 16; i++) add_stim(rand_alu_instr(), $urandom, $urandom, $urandom);
        run(100, 0, 40);
        check_eq("fr_count", en_cnt, 16);
        check_eq("fr_cycles", cyc, 17);

        // Async reset with two entries held
        add_stim(rand_alu_instr(), 0, $urandom, $urandom);
        add_stim(rand_alu_instr(), 0, $urandom, $urandom);
        add_stim(rand_alu_instr(), 0, $urandom, $urandom);
        stall_s = 0; stall_l = 1000; cyc = 0;
        apply();
        repeat (3) step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_in_ready", in_ready, 1);
        check_eq("arst_alu_en", alu_en, 0);
        check_eq("arst_op1", op1, 0);
        check_eq("arst_rd", rd, 0);
        stim_q.delete();
        exp_q.delete();
        ill_exp = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        add_stim(32'h002081B3, 32'h0, 32'd9, 32'd11);
        run(100, 0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
